// File: rtl/niu_muldiv.sv
// rtl/niu_muldiv.sv - iterative multiply/divide unit, one shift step per cycle, fixed latency
module niu_muldiv #(
    parameter int WORD_SIZE = 32,
    parameter int OP_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OP_BITS-1:0]   op,
    input  logic                 sgn,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic                 div_by_zero
);
    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(WORD_SIZE + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [OP_BITS-1:0] op_q, op_d;
    logic           sgn_q, sgn_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mq_q, mq_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           nrem_q, nrem_d;
    logic           bz_q, bz_d;
    logic [W-1:0]   result_q, result_d;
    logic           dbz_q, dbz_d;

    logic           is_div;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_diff;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sgn_q    <= 1'b0;
            a_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            nrem_q   <= 1'b0;
            bz_q     <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sgn_q    <= sgn_d;
            a_q      <= a_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            nrem_q   <= nrem_d;
            bz_q     <= bz_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        a_d      = a_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        nrem_d   = nrem_q;
        bz_d     = bz_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        is_div   = (op_q == OP_BITS'(2)) || (op_q == OP_BITS'(3));
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        // acc stays below the divisor, so bit W of the difference is a clean borrow flag
        rem_sh   = {acc_q, mq_q[W-1]};
        rem_diff = rem_sh - {1'b0, mcand_q};
        prod     = {acc_q, mq_q};
        prod_fix = neg_q ? -prod : prod;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    sgn_d   = sgn;
                    a_d     = a;
                    mcand_d = b;
                    state_d = PREP;
                end
            end
            PREP: begin
                mq_d    = (sgn_q && a_q[W-1]) ? -a_q : a_q;
                mcand_d = (sgn_q && mcand_q[W-1]) ? -mcand_q : mcand_q;
                neg_d   = sgn_q && (a_q[W-1] ^ mcand_q[W-1]);
                nrem_d  = sgn_q && a_q[W-1];
                bz_d    = (mcand_q == '0);
                acc_d   = '0;
                cnt_d   = CW'(W);
                state_d = CALC;
            end
            CALC: begin
                if (is_div) begin
                    if (!rem_diff[W]) begin
                        acc_d = rem_diff[W-1:0];
                        mq_d  = {mq_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[W-1:0];
                        mq_d  = {mq_q[W-2:0], 1'b0};
                    end
                end else begin
                    {acc_d, mq_d} = {mul_sum, mq_q[W-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q == OP_BITS'(0)) begin
                    result_d = prod_fix[W-1:0];
                end else if (op_q == OP_BITS'(1)) begin
                    result_d = prod_fix[2*W-1:W];
                end else if (op_q == OP_BITS'(2)) begin
                    result_d = bz_q ? {W{1'b1}} : (neg_q ? -mq_q : mq_q);
                end else begin
                    result_d = bz_q ? a_q : (nrem_q ? -acc_q : acc_q);
                end
                dbz_d   = is_div && bz_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;
endmodule
